// File: rtl/add_share_pkg.sv
// Shared types and constants for the two-requester shared-adder arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package add_share_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Requester index: 0 or 1.
  typedef logic req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // last_grant out of reset; set to 1 so requester 0 wins the first contention.
  localparam req_id_t RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/add_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter producing a one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: enable low (result register cannot take a new result) forces grant to zero.
// Ports: valid[1:0] request pair, last_grant previous winner, enable accept window,
//        grant[1:0] one-hot winner (all zero when disabled or idle).
module rr_arb2 (
  input  logic       enable,
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Contention: the requester that did not win last time gets it.
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin share of one WIDTH-bit adder between two requesters.
// Latency: operands accepted at edge N appear on resp_* in cycle N+1; one result per cycle sustained.
// Backpressure: resp_ready low with a result pending holds resp_* and drops both req readies.
// Ports: clk, reset (sync, active-high); reqN_valid/reqN_a/reqN_b in, reqN_ready out (N=0,1);
//        resp_valid/resp_id/resp_sum/resp_carry out, resp_ready in.
// Optional: define ADD_SHARE_SIGNED_OVF_EN to add resp_sovf (two's-complement signed overflow).
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_carry,
`ifdef ADD_SHARE_SIGNED_OVF_EN
  output logic             resp_sovf,
`endif
  input  logic             resp_ready
);

  state_t     state;
  req_id_t    last_grant;
  logic       can_accept;
  logic [1:0] grant;
  req_id_t    win_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum_full;

  // A full register that is draining this cycle can be refilled in the same cycle.
  assign can_accept = (state == EMPTY) | (resp_ready & resp_valid);

  rr_arb2 u_arb (
    .enable     (can_accept),
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign win_id     = grant[1];

  // Operand mux feeding the single shared adder.
  assign op_a     = grant[1] ? req1_a : req0_a;
  assign op_b     = grant[1] ? req1_b : req0_b;
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      last_grant <= RESET_LAST_GRANT;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
`ifdef ADD_SHARE_SIGNED_OVF_EN
      resp_sovf  <= 1'b0;
`endif
    end else if (|grant) begin
      state      <= FULL;
      last_grant <= win_id;
      resp_valid <= 1'b1;
      resp_id    <= win_id;
      resp_sum   <= sum_full[WIDTH-1:0];
      resp_carry <= sum_full[WIDTH];
`ifdef ADD_SHARE_SIGNED_OVF_EN
      // Like-signed operands whose sum has flipped sign.
      resp_sovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != op_a[WIDTH-1]);
`endif
    end else if ((state == FULL) && resp_ready) begin
      // Drained with nothing to refill; data fields keep their last value.
      state      <= EMPTY;
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: directed-vector bench for add_share_arb.
// Latency: n/a.
// Backpressure: n/a.
module tb_add_share_arb;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         resp_valid, resp_id, resp_carry;
  logic [W-1:0] resp_sum;
  logic         resp_ready;
`ifdef ADD_SHARE_SIGNED_OVF_EN
  logic         resp_sovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_share_arb #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
`ifdef ADD_SHARE_SIGNED_OVF_EN
    .resp_sovf  (resp_sovf),
`endif
    .resp_ready (resp_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic id,
                            input logic [W-1:0] sum, input logic c);
    check({tag, ".valid"}, 64'(resp_valid), 64'(v));
    check({tag, ".id"},    64'(resp_id),    64'(id));
    check({tag, ".sum"},   64'(resp_sum),   64'(sum));
    check({tag, ".carry"}, 64'(resp_carry), 64'(c));
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    #1;
    check({tag, ".rdy0"}, 64'(req0_ready), 64'(r0));
    check({tag, ".rdy1"}, 64'(req1_ready), 64'(r1));
  endtask

  initial begin
    logic exp_id;

    reset = 1'b1;
    resp_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    step();
    reset = 1'b0;
    check_resp("reset", 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef ADD_SHARE_SIGNED_OVF_EN
    check("reset.sovf", 64'(resp_sovf), 64'd0);
`endif
    check_rdy("idle", 1'b0, 1'b0);

    // Single request from requester 0.
    drive(1'b1, 32'h5, 32'h3, 1'b0, '0, '0);
    check_rdy("single", 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check_resp("single", 1'b1, 1'b0, 32'h8, 1'b0);
    resp_ready = 1'b1;
    step();
    check("drain.valid", 64'(resp_valid), 64'd0);
    check("drain.sum_held", 64'(resp_sum), 64'h8);

    // Carry wrap from requester 1.
    drive(1'b0, '0, '0, 1'b1, 32'hFFFF_FFFF, 32'h1);
    check_rdy("wrap", 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check_resp("wrap", 1'b1, 1'b1, 32'h0, 1'b1);
`ifdef ADD_SHARE_SIGNED_OVF_EN
    check("wrap.sovf", 64'(resp_sovf), 64'd0);
    step();
    // Signed overflow without carry, also via requester 1 so priority matches the default build.
    drive(1'b0, '0, '0, 1'b1, 32'h7FFF_FFFF, 32'h1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check_resp("sovf", 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    check("sovf.sovf", 64'(resp_sovf), 64'd1);
`endif
    step();
    check("drain2.valid", 64'(resp_valid), 64'd0);

    // Contention: last grant was requester 1, so alternation starts at 0.
    drive(1'b1, 32'd10, 32'd1, 1'b1, 32'd20, 32'd2);
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      check_rdy($sformatf("alt%0d", i), ~exp_id, exp_id);
      step();
      check_resp($sformatf("alt%0d", i), 1'b1, exp_id,
                 exp_id ? 32'd22 : 32'd11, 1'b0);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("drain3.valid", 64'(resp_valid), 64'd0);

    // Backpressure: pending result from requester 0, then both requesters wait.
    resp_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h2, 1'b0, '0, '0);
    step();
    drive(1'b1, 32'd10, 32'd1, 1'b1, 32'd20, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      step();
      check_resp($sformatf("bp%0d", i), 1'b1, 1'b0, 32'h3, 1'b0);
    end
    resp_ready = 1'b1;
    check_rdy("bp_release", 1'b0, 1'b1);
    step();
    check_resp("bp_refill", 1'b1, 1'b1, 32'd22, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();

    // Idle cycles must not rotate priority.
    drive(1'b1, 32'h4, 32'h4, 1'b0, '0, '0);
    step();
    check_resp("idle_g0", 1'b1, 1'b0, 32'h8, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    step();
    drive(1'b1, 32'd10, 32'd1, 1'b1, 32'd20, 32'd2);
    check_rdy("idle_norot", 1'b0, 1'b1);
    step();
    check_resp("idle_norot", 1'b1, 1'b1, 32'd22, 1'b0);

    // Mid-operation reset with requester 0 as last winner.
    drive(1'b1, 32'h6, 32'h6, 1'b0, '0, '0);
    step();
    resp_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check_resp("pre_rst", 1'b1, 1'b0, 32'hC, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_resp("mid_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    resp_ready = 1'b1;
    drive(1'b1, 32'd10, 32'd1, 1'b1, 32'd20, 32'd2);
    check_rdy("post_rst", 1'b1, 1'b0);
    step();
    check_resp("post_rst", 1'b1, 1'b0, 32'd11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Arbitrates two independent requesters onto one shared WIDTH-bit unsigned adder (sum plus carry-out).
- Grants round-robin, registers one result, and returns it with the winning requester's ID over a valid/ready response channel.
- Sits between the two client datapaths and the adder resource; clients never drive the adder directly.

Parameters:
- WIDTH, 32, operand and sum width in bits; carry is bit WIDTH of the full sum.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_ready  out  1  requester 0 operand pair accepted this cycle.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- req1_ready  out  1  requester 1 operand pair accepted this cycle.
- resp_valid  out  1  result register holds a valid result.
- resp_id  out  1  requester index owning the result.
- resp_sum  out  WIDTH  low WIDTH bits of a+b.
- resp_carry  out  1  carry-out (bit WIDTH of a+b).
- resp_ready  in  1  consumer accepts the result this cycle.

Behaviour:
- Reset (synchronous, active-high): resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, last_grant=1 (so requester 0 wins first), state=EMPTY.
- State machine, 2 states:
  - EMPTY: result register free.
  - FULL: result register holds an undelivered result.
- can_accept = (state==EMPTY) | (resp_ready & resp_valid). A full register drains and refills in the same cycle, giving sustained one result per cycle.
- Grant rules, evaluated only when can_accept:
  - Only one valid: it wins.
  - Both valid: the requester != last_grant wins.
  - Neither valid: no grant.
- reqN_ready = grant to N. The ready signals are combinational from valids, state and resp_ready. At most one ready is high per cycle.
- On grant:
  - {resp_carry, resp_sum} <= a + b, computed at WIDTH+1 bits, unsigned.
  - resp_id <= winner; last_grant <= winner; resp_valid <= 1; state <= FULL.
- FULL with resp_ready=1 and no grant: resp_valid <= 0, state <= EMPTY. Data fields hold their last value.
- FULL with resp_ready=0: all result fields held stable, both ready=0 (backpressure).
- Latency: accept at edge N, resp_valid high after edge N, i.e. in cycle N+1.
- Wrap-around: a+b overflowing 2^WIDTH sets carry=1; sum is the modulo result. Example: FFFFFFFF+1 gives sum 0, carry 1.
- last_grant updates only on an actual grant; idle cycles do not rotate priority.
- Reset mid-operation: a pending result is discarded, resp_valid drops the cycle after reset is sampled, and last_grant returns to 1.
- Requester inputs are sampled only in the grant cycle. A requester holding valid without ready keeps waiting, and no starvation beyond one cycle occurs under contention.

Optional Feature:
- Macro: ADD_SHARE_SIGNED_OVF_EN.
- Defined:
  - Adds output port resp_sovf (1 bit), registered with the result.
  - resp_sovf = two's-complement signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
  - Reset value of resp_sovf is 0; it is held under backpressure like the other fields.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package add_share_pkg holds:
  - default WIDTH constant;
  - req_id_t (1-bit requester index);
  - state_t enum {EMPTY, FULL};
  - RESET_LAST_GRANT constant (1).
- One natural sub-module: rr_arb2. Inputs: valid pair, last_grant, enable. Outputs: one-hot grant. Purely combinational.
- The adder and the result register stay in the top module.

Test Plan:
- Reset then single request: req0 a=00000005 b=00000003 → req0_ready=1 that cycle; next cycle resp_valid=1, id=0, sum=00000008, carry=0.
- Carry wrap: req1 a=FFFFFFFF b=00000001 → id=1, sum=00000000, carry=1. With ADD_SHARE_SIGNED_OVF_EN, 7FFFFFFF+1 gives resp_sovf=1, carry=0.
- Contention alternation: both valid continuously, resp_ready=1 → grants 0,1,0,1. One result per cycle with ids alternating, starting with 0 after reset.
- Backpressure: result pending, resp_ready=0 for 3 cycles while both requesters valid → both readies 0, resp fields unchanged. When resp_ready rises, drain and refill in the same cycle.
- Idle does not rotate: grant req0, idle 2 cycles, then both valid → req1 wins.
- Reset mid-operation: assert reset while resp_valid=1 and resp_ready=0 → next cycle resp_valid=0. The first later contended grant goes to req0.
